// File: rtl/scan_display_capture_if.sv
// Display-bus bundle between a multiplexed 7-segment driver (master) and the
// capture block (slave) that rebuilds the displayed digits.
interface scan_display_capture_if;
    logic [7:0]  seg_data;
    logic [5:0]  c_pin;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  seen;
    logic        frame_done;
    logic        decode_err;
    logic        stall;

    modport master (
        output seg_data, c_pin,
        input  digits, dp, seen, frame_done, decode_err, stall
    );

    modport slave (
        input  seg_data, c_pin,
        output digits, dp, seen, frame_done, decode_err, stall
    );
endinterface

// File: rtl/scan_display_capture.sv
// Rebuilds the six digit values shown on a multiplexed 7-segment display by
// watching its segment and digit-select buses; flags frames, decode errors, stalls.
module scan_display_capture #(
    parameter int SETTLE         = 4,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int TIMEOUT        = 1000000
) (
    input  logic                  clock,
    input  logic                  rst,
    scan_display_capture_if.slave bus
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    // Inactive bus level; also the XOR mask that normalises polarity.
    localparam logic [7:0] SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [5:0] SEL_IDLE = SEL_ACTIVE_LOW ? 6'h3F : 6'h00;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} state_t;
    localparam state_t RELATCH_ST = (SETTLE <= 1) ? S_CAPTURE : S_SETTLE;

    logic [7:0] seg_s1_q, seg_s2_q;
    logic [5:0] sel_s1_q, sel_s2_q;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            seg_s1_q <= SEG_IDLE;
            seg_s2_q <= SEG_IDLE;
            sel_s1_q <= SEL_IDLE;
            sel_s2_q <= SEL_IDLE;
        end else begin
            seg_s1_q <= bus.seg_data;
            seg_s2_q <= seg_s1_q;
            sel_s1_q <= bus.c_pin;
            sel_s2_q <= sel_s1_q;
        end
    end

    logic [7:0] seg_n;
    logic [5:0] sel_n;
    logic [2:0] sel_cnt;
    logic [2:0] sel_k;
    logic       sel_vld;

    assign seg_n = seg_s2_q ^ SEG_IDLE;
    assign sel_n = sel_s2_q ^ SEL_IDLE;

    always_comb begin
        sel_cnt = '0;
        sel_k   = '0;
        for (int i = 0; i < 6; i++) begin
            if (sel_n[i]) begin
                sel_cnt = sel_cnt + 3'd1;
                sel_k   = 3'(i);
            end
        end
    end

    // Anything other than exactly one selected digit is treated as blanking.
    assign sel_vld = (sel_cnt == 3'd1);

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h3F:   seg_decode = 4'h0;
            7'h06:   seg_decode = 4'h1;
            7'h5B:   seg_decode = 4'h2;
            7'h4F:   seg_decode = 4'h3;
            7'h66:   seg_decode = 4'h4;
            7'h6D:   seg_decode = 4'h5;
            7'h7D:   seg_decode = 4'h6;
            7'h07:   seg_decode = 4'h7;
            7'h7F:   seg_decode = 4'h8;
            7'h6F:   seg_decode = 4'h9;
            7'h00:   seg_decode = 4'hE;
            7'h40:   seg_decode = 4'hD;
            default: seg_decode = 4'hF;
        endcase
    endfunction

    state_t          state_q;
    logic [2:0]      lat_k_q;
    logic [7:0]      lat_seg_q;
    logic [CW-1:0]   cnt_q;
    logic [5:0][3:0] digits_q;
    logic [5:0]      dp_q;
    logic [5:0]      seen_q;
    logic            frame_done_q;
    logic            decode_err_q;

    logic            same;
    logic [3:0]      cap_val;
    logic [5:0]      seen_upd;

    assign same     = sel_vld && (sel_k == lat_k_q) && (seg_n == lat_seg_q);
    assign cap_val  = seg_decode(lat_seg_q[6:0]);
    assign seen_upd = seen_q | (6'b1 << lat_k_q);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            lat_k_q      <= '0;
            lat_seg_q    <= '0;
            cnt_q        <= '0;
            digits_q     <= {6{4'hE}};
            dp_q         <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            decode_err_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_vld) begin
                        lat_k_q   <= sel_k;
                        lat_seg_q <= seg_n;
                        cnt_q     <= CW'(1);
                        state_q   <= RELATCH_ST;
                    end
                end
                S_SETTLE: begin
                    if (!sel_vld) begin
                        state_q <= S_IDLE;
                    end else if (same) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(SETTLE - 1)) state_q <= S_CAPTURE;
                    end else begin
                        lat_k_q   <= sel_k;
                        lat_seg_q <= seg_n;
                        cnt_q     <= CW'(1);
                        state_q   <= RELATCH_ST;
                    end
                end
                S_CAPTURE: begin
                    digits_q[lat_k_q] <= cap_val;
                    dp_q[lat_k_q]     <= lat_seg_q[7];
                    if (cap_val == 4'hF) decode_err_q <= 1'b1;
                    // The capture that completes the set closes the frame.
                    if (seen_upd == 6'h3F) begin
                        seen_q       <= '0;
                        frame_done_q <= 1'b1;
                    end else begin
                        seen_q <= seen_upd;
                    end
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (!same) begin
                        if (!sel_vld) begin
                            state_q <= S_IDLE;
                        end else begin
                            lat_k_q   <= sel_k;
                            lat_seg_q <= seg_n;
                            cnt_q     <= CW'(1);
                            state_q   <= RELATCH_ST;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [TW-1:0] tmr_q, tmr_d;

    always_comb begin
        tmr_d = tmr_q;
        if (frame_done_q)                tmr_d = '0;
        else if (tmr_q != TW'(TIMEOUT))  tmr_d = tmr_q + TW'(1);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) tmr_q <= '0;
        else      tmr_q <= tmr_d;
    end

    assign bus.digits     = digits_q;
    assign bus.dp         = dp_q;
    assign bus.seen       = seen_q;
    assign bus.frame_done = frame_done_q;
    assign bus.decode_err = decode_err_q;
    assign bus.stall      = (tmr_q == TW'(TIMEOUT));
endmodule

// File: tb/tb_scan_display_capture.sv
// Directed bench for scan_display_capture: decode table plus hand-written
// frame, glitch, invalid-select, error, stall and mid-operation reset sequences.
module tb_scan_display_capture;
    logic clock;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    int   fd_cnt  = 0;

    scan_display_capture_if bus();

    scan_display_capture #(
        .SETTLE(4), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1), .TIMEOUT(100)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         k;
        logic [7:0] seg;
        logic [3:0] exp_d;
        logic       exp_dp;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Display-side encoder for building frames.
    function automatic logic [7:0] enc(input logic [3:0] v);
        case (v)
            4'h0: enc = 8'h3F; 4'h1: enc = 8'h06; 4'h2: enc = 8'h5B; 4'h3: enc = 8'h4F;
            4'h4: enc = 8'h66; 4'h5: enc = 8'h6D; 4'h6: enc = 8'h7D; 4'h7: enc = 8'h07;
            4'h8: enc = 8'h7F; 4'h9: enc = 8'h6F; 4'hD: enc = 8'h40;
            default: enc = 8'h00;
        endcase
    endfunction

    task automatic tick(input int cyc);
        repeat (cyc) begin
            @(negedge clock);
            if (bus.frame_done) fd_cnt++;
        end
    endtask

    task automatic show(input int k, input logic [7:0] seg_ah, input int cyc);
        bus.c_pin    = ~(6'b1 << k);
        bus.seg_data = ~seg_ah;
        tick(cyc);
    endtask

    task automatic idle(input int cyc);
        bus.c_pin    = 6'h3F;
        bus.seg_data = 8'hFF;
        tick(cyc);
    endtask

    task automatic frame(input logic [23:0] val);
        for (int k = 0; k < 6; k++) show(k, enc(val[4*k +: 4]), 8);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b0;
        bus.c_pin    = 6'h3F;
        bus.seg_data = 8'hFF;
        repeat (2) @(negedge clock);
        rst    = 1'b1;
        fd_cnt = 0;
    endtask

    initial begin
        int first_fd;
        int cnt5;

        tbl[0]  = '{0, 8'h3F, 4'h0, 1'b0};
        tbl[1]  = '{1, 8'h06, 4'h1, 1'b0};
        tbl[2]  = '{2, 8'h5B, 4'h2, 1'b0};
        tbl[3]  = '{3, 8'h4F, 4'h3, 1'b0};
        tbl[4]  = '{4, 8'h66, 4'h4, 1'b0};
        tbl[5]  = '{5, 8'h6D, 4'h5, 1'b0};
        tbl[6]  = '{0, 8'h7D, 4'h6, 1'b0};
        tbl[7]  = '{1, 8'h87, 4'h7, 1'b1};
        tbl[8]  = '{2, 8'h7F, 4'h8, 1'b0};
        tbl[9]  = '{3, 8'hEF, 4'h9, 1'b1};
        tbl[10] = '{4, 8'h80, 4'hE, 1'b1};
        tbl[11] = '{5, 8'h40, 4'hD, 1'b0};
        tbl[12] = '{0, 8'h6F, 4'h9, 1'b0};

        // Reset held with live inputs toggling.
        rst          = 1'b0;
        bus.c_pin    = 6'h3E;
        bus.seg_data = ~8'h06;
        repeat (3) @(negedge clock);
        bus.c_pin    = 6'h3D;
        bus.seg_data = ~8'h5B;
        repeat (8) @(negedge clock);
        chk("rst_digits", bus.digits, 24'hEEEEEE);
        chk("rst_dp", bus.dp, 6'h00);
        chk("rst_seen", bus.seen, 6'h00);
        chk("rst_flags", {bus.frame_done, bus.decode_err, bus.stall}, 3'b000);
        rst = 1'b1;
        idle(10);
        chk("post_rst_digits", bus.digits, 24'hEEEEEE);
        chk("post_rst_seen", bus.seen, 6'h00);
        chk("post_rst_fd", fd_cnt, 0);

        // Decode table: each pattern held 8 cycles, captured by the 7th.
        for (int i = 0; i < 13; i++) begin
            show(tbl[i].k, tbl[i].seg, 8);
            chk($sformatf("tbl%0d_digit", i), bus.digits[4*tbl[i].k +: 4], tbl[i].exp_d);
            chk($sformatf("tbl%0d_dp", i), bus.dp[tbl[i].k], tbl[i].exp_dp);
            chk($sformatf("tbl%0d_err", i), bus.decode_err, 1'b0);
        end

        // Clean frame with latency check on the last digit.
        do_reset();
        show(0, enc(4'h1), 8);
        show(1, enc(4'h2), 8);
        show(2, enc(4'h0), 8);
        show(3, enc(4'h0), 8);
        show(4, enc(4'h2), 8);
        chk("frame_seen_partial", bus.seen, 6'h1F);
        chk("frame_no_early_fd", fd_cnt, 0);
        bus.c_pin    = ~6'b100000;
        bus.seg_data = ~enc(4'h4);
        first_fd = 0;
        cnt5     = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (bus.frame_done) begin
                cnt5++;
                if (first_fd == 0) first_fd = i;
            end
        end
        chk("frame_fd_latency", first_fd, 7);
        chk("frame_fd_count", cnt5, 1);
        chk("frame_digits", bus.digits, 24'h420021);
        chk("frame_seen_clr", bus.seen, 6'h00);

        // Segments changing every 2 cycles never settle.
        fd_cnt = 0;
        for (int i = 0; i < 10; i++) show(0, (i % 2 == 1) ? 8'h7F : 8'h07, 2);
        idle(6);
        chk("glitch_digits", bus.digits, 24'h420021);
        chk("glitch_seen", bus.seen, 6'h00);
        chk("glitch_fd", fd_cnt, 0);

        // Two, none and all digits selected are all blanking.
        bus.seg_data = ~8'h7F;
        bus.c_pin = 6'b111100; tick(10);
        bus.c_pin = 6'b111111; tick(10);
        bus.c_pin = 6'b000000; tick(10);
        idle(4);
        chk("inval_digits", bus.digits, 24'h420021);
        chk("inval_seen", bus.seen, 6'h00);
        chk("inval_fd", fd_cnt, 0);

        // Unrecognised pattern, then a full valid frame: error stays sticky.
        show(2, 8'h49, 8);
        chk("err_digit", bus.digits[11:8], 4'hF);
        chk("err_flag", bus.decode_err, 1'b1);
        fd_cnt = 0;
        frame(24'h987654);
        chk("err_frame_digits", bus.digits, 24'h987654);
        chk("err_sticky", bus.decode_err, 1'b1);
        chk("err_frame_fd", fd_cnt, 1);

        // Stall after TIMEOUT idle cycles, cleared the cycle after frame_done.
        do_reset();
        tick(99);
        chk("stall_before", bus.stall, 1'b0);
        tick(1);
        chk("stall_at_100", bus.stall, 1'b1);
        tick(20);
        chk("stall_saturate", bus.stall, 1'b1);
        for (int k = 0; k < 5; k++) show(k, enc(4'(k)), 8);
        bus.c_pin    = ~6'b100000;
        bus.seg_data = ~enc(4'h5);
        repeat (7) @(negedge clock);
        chk("stall_fd_pulse", bus.frame_done, 1'b1);
        chk("stall_during_fd", bus.stall, 1'b1);
        @(negedge clock);
        chk("stall_cleared", bus.stall, 1'b0);
        chk("stall_frame_digits", bus.digits, 24'h543210);

        // Reset asserted mid-SETTLE after three captures.
        do_reset();
        show(0, enc(4'h7), 8);
        show(1, enc(4'h8), 8);
        show(2, enc(4'h9), 8);
        chk("mid_seen", bus.seen, 6'h07);
        show(3, enc(4'h3), 4);
        rst = 1'b0;
        #1;
        chk("mid_rst_digits", bus.digits, 24'hEEEEEE);
        chk("mid_rst_seen", bus.seen, 6'h00);
        chk("mid_rst_dp", bus.dp, 6'h00);
        @(negedge clock);
        rst    = 1'b1;
        fd_cnt = 0;
        frame(24'h012345);
        chk("mid_frame_digits", bus.digits, 24'h012345);
        chk("mid_frame_fd", fd_cnt, 1);
        chk("mid_frame_err", bus.decode_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
